icache_ctrl_nway: RTL and testbench



---
 rtl/icache_ctrl_nway_pkg.sv | 34 +++
 rtl/icache_ctrl_nway_if.sv | 50 +++++
 rtl/icache_ctrl_nway_onehot_to_idx.sv | 19 +
 rtl/icache_ctrl_nway.sv | 164 ++++++++++++++++
 tb/tb_icache_ctrl_nway.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/icache_ctrl_nway_pkg.sv
// Shared definitions for the N-way instruction cache controller: FSM states,
// pipeline control bit positions, request op-codes and the request-accept decision.
package icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_LOOKUP       = 3'd1,
        ST_MISS_REQ     = 3'd2,
        ST_REFILL       = 3'd3,
        ST_REPLACE      = 3'd4,
        ST_REPLACE_HOLD = 3'd5,
        ST_OPERATION    = 3'd6
    } state_e;

    localparam int CTRL_STALL = 0;
    localparam int CTRL_FLUSH = 1;

    localparam logic OP_FETCH = 1'b0;
    localparam logic OP_INVAL = 1'b1;

    // Where a newly presented request sends the FSM; shared by IDLE, REPLACE and hit.
    function automatic state_e accept_next(input logic valid, input logic opflag);
        state_e nxt;
        if (!valid) begin
            nxt = ST_IDLE;
        end else if (opflag == OP_INVAL) begin
            nxt = ST_OPERATION;
        end else begin
            nxt = ST_LOOKUP;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/icache_ctrl_nway_if.sv
// Bundle of pipeline, memory-bus and array-control signals around the cache FSM.
// The slave modport is the controller's view; master is the surrounding cache.
interface icache_ctrl_nway_if #(
    parameter int WAY      = 2,
    parameter int OFFSET_W = 2,
    parameter int WAY_W    = $clog2(WAY)
) ();

    logic                pipeline_icache_valid;
    logic                icache_pipeline_ready;
    logic                pipeline_icache_opflag;
    logic [31:0]         pipeline_icache_ctrl;
    logic                icache_pipeline_stall;
    logic                icache_mem_req;
    logic [7:0]          icache_mem_len;
    logic                mem_icache_addrOK;
    logic                mem_icache_dataOK;
    logic                FSM_rbuf_we;
    logic [31:0]         FSM_rbuf_addr;
    logic [WAY-1:0]      FSM_hit;
    logic [WAY_W-1:0]    FSM_lru_way;
    logic [WAY-1:0]      FSM_use;
    logic [WAY-1:0]      FSM_Data_we;
    logic [WAY-1:0]      FSM_TagV_we;
    logic                FSM_TagV_clr;
    logic [OFFSET_W-1:0] FSM_refill_word;
    logic [WAY_W-1:0]    FSM_choose_way;
    logic                FSM_choose_return;

    modport slave (
        input  pipeline_icache_valid, pipeline_icache_opflag, pipeline_icache_ctrl,
        input  mem_icache_addrOK, mem_icache_dataOK,
        input  FSM_rbuf_addr, FSM_hit, FSM_lru_way,
        output icache_pipeline_ready, icache_pipeline_stall,
        output icache_mem_req, icache_mem_len,
        output FSM_rbuf_we, FSM_use, FSM_Data_we, FSM_TagV_we, FSM_TagV_clr,
        output FSM_refill_word, FSM_choose_way, FSM_choose_return
    );

    modport master (
        output pipeline_icache_valid, pipeline_icache_opflag, pipeline_icache_ctrl,
        output mem_icache_addrOK, mem_icache_dataOK,
        output FSM_rbuf_addr, FSM_hit, FSM_lru_way,
        input  icache_pipeline_ready, icache_pipeline_stall,
        input  icache_mem_req, icache_mem_len,
        input  FSM_rbuf_we, FSM_use, FSM_Data_we, FSM_TagV_we, FSM_TagV_clr,
        input  FSM_refill_word, FSM_choose_way, FSM_choose_return
    );

endinterface

// File: rtl/icache_ctrl_nway_onehot_to_idx.sv
// One-hot to binary index encoder used to turn the per-way hit vector into a
// read-mux select. An all-zero input encodes to 0.
module onehot_to_idx #(
    parameter int WAY   = 2,
    parameter int IDX_W = $clog2(WAY)
) (
    input  logic [WAY-1:0]   onehot_i,
    output logic [IDX_W-1:0] idx_o
);

    // OR the indices of all set bits; with at most one bit set this is exact.
    always_comb begin
        idx_o = {IDX_W{1'b0}};
        for (int i = 0; i < WAY; i++) begin
            idx_o = idx_o | (onehot_i[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

endmodule

// File: rtl/icache_ctrl_nway.sv
// Control FSM for the N-way L1 instruction cache: lookup, burst refill with
// critical-word forwarding, and set invalidation, driving the cache arrays.
module icache_ctrl_nway
    import icache_pkg::*;
#(
    parameter int WAY      = 2,
    parameter int OFFSET_W = 2,
    parameter int WAY_W    = $clog2(WAY)
) (
    input  logic              clk,
    input  logic              rst,
    icache_ctrl_nway_if.slave io
);

    localparam logic [OFFSET_W-1:0] LAST_WORD = {OFFSET_W{1'b1}};
    localparam logic [7:0]          BURST_LEN = 8'((1 << OFFSET_W) - 1);

    state_e              state_q, state_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;
    logic                flush_seen_q, flush_seen_d;

    logic [WAY_W-1:0]    hit_idx_s;
    logic [WAY-1:0]      victim_oh_s;
    logic [OFFSET_W-1:0] req_word_s;
    logic                hit_s, stall_s, flush_s;
    logic                unused_ok_s;

    logic                ready_s, rbuf_we_s, mem_req_s, tagv_clr_s, choose_return_s;
    logic [WAY-1:0]      use_s, data_we_s, tagv_we_s;
    logic [OFFSET_W-1:0] refill_word_s;
    logic [WAY_W-1:0]    choose_way_s;

    onehot_to_idx #(.WAY(WAY), .IDX_W(WAY_W)) u_hit_enc (
        .onehot_i (io.FSM_hit),
        .idx_o    (hit_idx_s)
    );

    assign hit_s       = |io.FSM_hit;
    assign stall_s     = io.pipeline_icache_ctrl[CTRL_STALL];
    assign flush_s     = io.pipeline_icache_ctrl[CTRL_FLUSH];
    assign req_word_s  = io.FSM_rbuf_addr[OFFSET_W+1:2];
    assign victim_oh_s = {{(WAY-1){1'b0}}, 1'b1} << victim_q;
    assign unused_ok_s = ^{io.pipeline_icache_ctrl[31:2], io.FSM_rbuf_addr[31:OFFSET_W+2],
                           io.FSM_rbuf_addr[1:0]};

    // State, victim way, beat counter and sticky flush flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            victim_q     <= {WAY_W{1'b0}};
            cnt_q        <= {OFFSET_W{1'b0}};
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            cnt_q        <= cnt_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // Next-state and array/pipeline control decode.
    always_comb begin
        state_d         = state_q;
        victim_d        = victim_q;
        cnt_d           = cnt_q;
        flush_seen_d    = flush_seen_q;
        ready_s         = 1'b0;
        rbuf_we_s       = 1'b0;
        mem_req_s       = 1'b0;
        tagv_clr_s      = 1'b0;
        choose_return_s = 1'b0;
        use_s           = {WAY{1'b0}};
        data_we_s       = {WAY{1'b0}};
        tagv_we_s       = {WAY{1'b0}};
        refill_word_s   = {OFFSET_W{1'b0}};
        choose_way_s    = {WAY_W{1'b0}};
        case (state_q)
            ST_IDLE, ST_REPLACE: begin
                ready_s   = 1'b1;
                rbuf_we_s = io.pipeline_icache_valid;
                state_d   = accept_next(io.pipeline_icache_valid, io.pipeline_icache_opflag);
            end
            ST_LOOKUP: begin
                if (hit_s) begin
                    ready_s      = 1'b1;
                    choose_way_s = hit_idx_s;
                    use_s        = io.FSM_hit;
                    rbuf_we_s    = io.pipeline_icache_valid;
                    state_d      = accept_next(io.pipeline_icache_valid, io.pipeline_icache_opflag);
                end else if (flush_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d      = ST_MISS_REQ;
                    victim_d     = io.FSM_lru_way;
                    flush_seen_d = 1'b0;
                end
            end
            ST_MISS_REQ: begin
                mem_req_s    = 1'b1;
                flush_seen_d = flush_seen_q | flush_s;
                if (io.mem_icache_addrOK) begin
                    state_d = ST_REFILL;
                    cnt_d   = {OFFSET_W{1'b0}};
                end else begin
                    state_d = ST_MISS_REQ;
                end
            end
            ST_REFILL: begin
                flush_seen_d = flush_seen_q | flush_s;
                if (io.mem_icache_dataOK) begin
                    data_we_s     = victim_oh_s;
                    refill_word_s = cnt_q;
                    cnt_d         = cnt_q + OFFSET_W'(1);
                    // A flush anywhere since the miss kills the forwarded word.
                    if ((cnt_q == req_word_s) && !flush_seen_q && !flush_s) begin
                        ready_s         = 1'b1;
                        choose_return_s = 1'b1;
                        choose_way_s    = victim_q;
                    end else begin
                        ready_s = 1'b0;
                    end
                    if (cnt_q == LAST_WORD) begin
                        tagv_we_s = victim_oh_s;
                        use_s     = victim_oh_s;
                        state_d   = stall_s ? ST_REPLACE_HOLD : ST_REPLACE;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_REPLACE_HOLD: begin
                ready_s      = !flush_seen_q;
                choose_way_s = victim_q;
                state_d      = ST_REPLACE;
            end
            ST_OPERATION: begin
                tagv_we_s  = {WAY{1'b1}};
                tagv_clr_s = 1'b1;
                ready_s    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign io.icache_pipeline_ready = rst ? 1'b0 : ready_s;
    assign io.icache_pipeline_stall = rst ? 1'b0 : ready_s;
    assign io.icache_mem_req        = rst ? 1'b0 : mem_req_s;
    assign io.icache_mem_len        = rst ? 8'd0 : BURST_LEN;
    assign io.FSM_rbuf_we           = rst ? 1'b0 : rbuf_we_s;
    assign io.FSM_use               = rst ? {WAY{1'b0}} : use_s;
    assign io.FSM_Data_we           = rst ? {WAY{1'b0}} : data_we_s;
    assign io.FSM_TagV_we           = rst ? {WAY{1'b0}} : tagv_we_s;
    assign io.FSM_TagV_clr          = rst ? 1'b0 : tagv_clr_s;
    assign io.FSM_refill_word       = rst ? {OFFSET_W{1'b0}} : refill_word_s;
    assign io.FSM_choose_way        = rst ? {WAY_W{1'b0}} : choose_way_s;
    assign io.FSM_choose_return     = rst ? 1'b0 : choose_return_s;

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Directed bench for icache_ctrl_nway with WAY=4, OFFSET_W=2: hits, misses with
// critical-word forwarding, stall hold, flush, invalidate op and reset mid-refill.
module tb_icache_ctrl_nway;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    logic [31:0] e_idle, e_acc, e_zero, e_mreq;

    icache_ctrl_nway_if #(.WAY(4), .OFFSET_W(2)) io ();

    icache_ctrl_nway #(.WAY(4), .OFFSET_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic r, input logic we, input logic mr,
                                       input logic clr, input logic cr,
                                       input logic [3:0] u, input logic [3:0] dwe,
                                       input logic [3:0] twe, input logic [1:0] rw,
                                       input logic [1:0] cw);
        return {11'd0, r, we, mr, clr, cr, u, dwe, twe, rw, cw};
    endfunction

    function automatic logic [31:0] obs();
        return {11'd0, io.icache_pipeline_ready, io.FSM_rbuf_we, io.icache_mem_req,
                io.FSM_TagV_clr, io.FSM_choose_return, io.FSM_use, io.FSM_Data_we,
                io.FSM_TagV_we, io.FSM_refill_word, io.FSM_choose_way};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, o, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [31:0] e);
        #2;
        chk(tag, obs(), e);
        tick();
    endtask

    // Accept a fetch in IDLE, miss in LOOKUP, get addrOK in the first MISS_REQ cycle.
    task automatic to_refill(input string tag);
        io.pipeline_icache_valid = 1'b1;
        step({tag, "_acc"}, e_acc);
        io.pipeline_icache_valid = 1'b0;
        step({tag, "_lookup"}, e_zero);
        io.mem_icache_addrOK = 1'b1;
        step({tag, "_req"}, e_mreq);
        io.mem_icache_addrOK = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        e_idle = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0);
        e_acc  = pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0);
        e_zero = 32'd0;
        e_mreq = pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0);

        rst                       = 1'b1;
        io.pipeline_icache_valid  = 1'b0;
        io.pipeline_icache_opflag = 1'b0;
        io.pipeline_icache_ctrl   = 32'd0;
        io.mem_icache_addrOK      = 1'b0;
        io.mem_icache_dataOK      = 1'b0;
        io.FSM_rbuf_addr          = 32'h0000_1004;
        io.FSM_hit                = 4'b0000;
        io.FSM_lru_way            = 2'd3;

        #2;
        chk("reset_outs", obs(), e_zero);
        chk("reset_len", {24'd0, io.icache_mem_len}, 32'd0);
        chk("reset_stall", {31'd0, io.icache_pipeline_stall}, 32'd0);
        tick();
        rst = 1'b0;
        #2;
        chk("len_after_reset", {24'd0, io.icache_mem_len}, 32'd3);
        chk("stall_eq_ready", {31'd0, io.icache_pipeline_stall}, 32'd1);
        step("idle", e_idle);

        // back-to-back hits in way 2
        io.pipeline_icache_valid = 1'b1;
        step("hit_accept", e_acc);
        io.FSM_hit = 4'b0100;
        step("hit_b2b_0", pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'h0, 4'h0, 2'd0, 2'd2));
        step("hit_b2b_1", pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'h0, 4'h0, 2'd0, 2'd2));
        io.pipeline_icache_valid = 1'b0;
        step("hit_last", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'h0, 4'h0, 2'd0, 2'd2));
        io.FSM_hit = 4'b0000;
        step("hit_back_idle", e_idle);

        // miss with flush in LOOKUP issues no memory request
        io.pipeline_icache_valid = 1'b1;
        step("fm_acc", e_acc);
        io.pipeline_icache_valid = 1'b0;
        io.pipeline_icache_ctrl  = 32'd2;
        step("fm_lookup", e_zero);
        io.pipeline_icache_ctrl  = 32'd0;
        step("fm_idle", e_idle);

        // miss, addrOK after two waiting cycles, gap before the first beat
        io.pipeline_icache_valid = 1'b1;
        step("m_acc", e_acc);
        io.pipeline_icache_valid = 1'b0;
        step("m_lookup", e_zero);
        step("m_req0", e_mreq);
        step("m_req1", e_mreq);
        io.mem_icache_addrOK = 1'b1;
        step("m_req2", e_mreq);
        io.mem_icache_addrOK = 1'b0;
        step("m_gap", e_zero);
        io.mem_icache_dataOK = 1'b1;
        step("m_beat0", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0, 2'd0, 2'd0));
        step("m_beat1", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'b1000, 4'h0, 2'd1, 2'd3));
        step("m_beat2", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0, 2'd2, 2'd0));
        step("m_beat3", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 2'd0));
        io.mem_icache_dataOK = 1'b0;
        step("m_replace", e_idle);
        io.mem_icache_dataOK = 1'b1;
        step("m_idle_dataok_ignored", e_idle);
        io.mem_icache_dataOK = 1'b0;

        // stall on the last beat goes through REPLACE_HOLD
        to_refill("s");
        io.mem_icache_dataOK = 1'b1;
        step("s_beat0", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0, 2'd0, 2'd0));
        step("s_beat1", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'b1000, 4'h0, 2'd1, 2'd3));
        step("s_beat2", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0, 2'd2, 2'd0));
        io.pipeline_icache_ctrl = 32'd1;
        step("s_beat3", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 2'd0));
        io.pipeline_icache_ctrl = 32'd0;
        io.mem_icache_dataOK    = 1'b0;
        step("s_hold", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 2'd3));
        step("s_replace", e_idle);
        step("s_idle", e_idle);

        // flush during refill: all beats written, no forwarded word
        to_refill("f");
        io.mem_icache_dataOK    = 1'b1;
        io.pipeline_icache_ctrl = 32'd2;
        step("f_beat0", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0, 2'd0, 2'd0));
        io.pipeline_icache_ctrl = 32'd0;
        step("f_beat1", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0, 2'd1, 2'd0));
        step("f_beat2", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0, 2'd2, 2'd0));
        step("f_beat3", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 2'd0));
        io.mem_icache_dataOK = 1'b0;
        step("f_replace", e_idle);
        step("f_idle", e_idle);

        // invalidate op
        io.pipeline_icache_valid  = 1'b1;
        io.pipeline_icache_opflag = 1'b1;
        step("op_acc", e_acc);
        io.pipeline_icache_valid  = 1'b0;
        io.pipeline_icache_opflag = 1'b0;
        step("op_inval", pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'b1111, 2'd0, 2'd0));
        step("op_idle", e_idle);

        // reset during beat 2
        to_refill("r");
        io.mem_icache_dataOK = 1'b1;
        step("r_beat0", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0, 2'd0, 2'd0));
        step("r_beat1", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'b1000, 4'h0, 2'd1, 2'd3));
        rst = 1'b1;
        step("r_rst_beat2", e_zero);
        rst = 1'b0;
        step("r_release", e_idle);
        step("r_idle2", e_idle);
        io.mem_icache_dataOK = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
